ring_counter_decoder: RTL and testbench
=======================================

# ring_counter_decoder

Receiving end of the one-hot ring counter interface: samples a WIDTH-bit ring (pattern rotates right each advance, 1000 → 0100 → 0010 → 0001 → 1000), decodes it to a binary position, and checks every advance is the legal successor of the previous sample. It acquires lock after consecutive good advances, counts full revolutions, and flags sequence faults. It sits beside any ring counter in the lab datapath as decoder plus integrity monitor.

## Interface
- WIDTH, 4, ring width (≥ 2); PW = clog2(WIDTH) is the position width
- LOCK_COUNT, 2, consecutive successor samples needed to go from SYNC to LOCK (1..15)
- Clock  in  1  rising-edge clock, the same clock as the ring counter
- Resetn  in  1  asynchronous, active-low reset
- Enable  in  1  sample qualifier; high when the ring advanced on this edge
- Ring  in  WIDTH  ring counter outputs, MSB is the stage loaded by Preset
- Clear  in  1  synchronous; zeroes Revolutions and ErrorSticky
- Position  out  PW  decoded index of the last legal sample
- Valid  out  1  last sample was exactly one-hot
- Locked  out  1  FSM in LOCK
- SeqError  out  1  one-cycle pulse on a fault while locked
- ErrorSticky  out  1  set by SeqError, cleared only by Clear or reset
- Revolutions  out  8  completed revolutions while locked, wraps 255 → 0
- Wrap  out  1  one-cycle pulse when Revolutions increments

## Operation
- Decode: Ring[WIDTH-1-k] set → Position = k. 1000 → 0, 0100 → 1, 0010 → 2, 0001 → 3.
- Legal sample: exactly one bit set. All-zero or multi-hot samples set Valid = 0 and leave Position unchanged.
- Successor of sample P is {P[0], P[WIDTH-1:1]}. The reference register `prev` holds the last legal sample.
- Enable low: all state holds, and SeqError and Wrap are 0 that cycle.
- FSM, evaluated only on edges where Enable is high:
  - HUNT: a legal sample loads prev, clears cnt and moves to SYNC. An illegal sample stays in HUNT.
  - SYNC: a successor sample increments cnt and loads prev; when cnt reaches LOCK_COUNT the FSM moves to LOCK. A legal non-successor sample clears cnt, reloads prev and stays in SYNC. An illegal sample moves to HUNT.
  - LOCK: a successor sample loads prev and stays in LOCK. Any fault pulses SeqError and sets ErrorSticky. Faults are:
    - a legal non-successor sample, including a repeat of prev: move to SYNC, cnt = 0, prev reloaded;
    - an illegal sample: move to HUNT.
- Revolutions increments, with a Wrap pulse, only in LOCK, on a successor sample where Position goes from WIDTH-1 to 0.
- Clear has priority over an increment in the same cycle: Revolutions = 0 and Wrap still pulses.
- A fault coinciding with Clear leaves ErrorSticky = 1 (set wins).

## Timing
- All outputs are registered. Position, Valid, Locked, SeqError and Wrap reflect the sample captured at the previous rising edge, a latency of 1 cycle.
- Reset (Resetn low, asynchronous, at any time including mid-lock) sets:
  - state = HUNT, cnt = 0, prev = 0;
  - Position = 0, Valid = 0, Locked = 0, SeqError = 0, ErrorSticky = 0, Revolutions = 0, Wrap = 0.
- Reset release is synchronous in effect: the first sample is taken at the first rising edge with Resetn high and Enable high.
- Lock latency with LOCK_COUNT = L: Locked rises after the edge capturing the (L+1)-th consecutive legal sample (the first sample plus L successors).
- SeqError and Wrap are high for exactly one cycle per event. Back-to-back events produce back-to-back pulses.
- Preset held on the source produces multi-hot samples (1100, 1110...). These are treated as illegal; no special case.

## Test plan
- Reset, then feed 1000, 0100, 0010, 0001, 1000 with Enable = 1 every cycle (WIDTH = 4, L = 2):
  - Position reads 0, 1, 2, 3, 0;
  - Locked = 1 from the cycle after 0010 is captured;
  - Revolutions = 1 and Wrap pulses once after the second 1000.
- While locked at 0100, feed 0001 (skip) → SeqError pulses one cycle, ErrorSticky = 1, Locked = 0 (SYNC). Then 1000, 0100 → Locked = 1 again.
- While locked, feed 0110 → Valid = 0, Position holds, SeqError pulses, state HUNT. Then feed 0000 → stays unlocked with no further SeqError.
- Locked sequence with Enable toggling 1/0 → state and outputs hold on Enable = 0 cycles. A repeated sample with Enable = 1 (0010, 0010) → SeqError.
- 256 full revolutions while locked → Revolutions wraps to 0, and Wrap pulses 256 times. Clear asserted on a wrap edge → Revolutions = 0. Clear together with a fault → ErrorSticky remains 1.
- Drop Resetn mid-lock, between edges → all outputs 0 immediately. After release, lock re-acquires from 1000 with the same latency as the first scenario.

Source files
------------

// File: rtl/ring_counter_decoder.sv
// Decoder and integrity monitor for a right-rotating one-hot ring counter.
// Tracks lock, counts full revolutions and flags sequence faults while locked.
module ring_counter_decoder #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned LOCK_COUNT = 2,
    localparam int unsigned PW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Ring,
    input  logic             Clear,
    output logic [PW-1:0]    Position,
    output logic             Valid,
    output logic             Locked,
    output logic             SeqError,
    output logic             ErrorSticky,
    output logic [7:0]       Revolutions,
    output logic             Wrap
);

    typedef enum logic [1:0] {StHunt, StSync, StLock} state_t;

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [PW-1:0]    position_q, position_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             seq_err_q, seq_err_d;
    logic             sticky_q, sticky_d;
    logic [7:0]       revs_q, revs_d;
    logic             wrap_q, wrap_d;

    logic             legal;
    logic             is_succ;
    logic             rev_inc;
    logic [PW-1:0]    dec;
    logic [WIDTH-1:0] succ_ring;
    logic [3:0]       cnt_inc;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign legal     = (Ring != '0) && ((Ring & (Ring - WIDTH'(1))) == '0);
    assign succ_ring = {prev_q[0], prev_q[WIDTH-1:1]};
    assign is_succ   = legal && (Ring == succ_ring);
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        dec = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (Ring[WIDTH-1-k]) dec = PW'(k);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        position_d = position_q;
        valid_d    = valid_q;
        seq_err_d  = 1'b0;
        rev_inc    = 1'b0;

        if (Enable) begin
            valid_d = legal;
            if (legal) position_d = dec;

            unique case (state_q)
                StHunt: begin
                    if (legal) begin
                        state_d = StSync;
                        cnt_d   = '0;
                        prev_d  = Ring;
                    end
                end
                StSync: begin
                    if (!legal) begin
                        state_d = StHunt;
                    end else if (is_succ) begin
                        cnt_d  = cnt_inc;
                        prev_d = Ring;
                        if (cnt_inc == LockCnt) state_d = StLock;
                    end else begin
                        cnt_d  = '0;
                        prev_d = Ring;
                    end
                end
                StLock: begin
                    if (!legal) begin
                        state_d   = StHunt;
                        seq_err_d = 1'b1;
                    end else if (is_succ) begin
                        // Leaving the last stage for the first one closes a revolution.
                        rev_inc = prev_q[0];
                        prev_d  = Ring;
                    end else begin
                        state_d   = StSync;
                        cnt_d     = '0;
                        prev_d    = Ring;
                        seq_err_d = 1'b1;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        locked_d = (state_d == StLock);
        wrap_d   = rev_inc;

        if (Clear)        revs_d = '0;
        else if (rev_inc) revs_d = revs_q + 8'd1;
        else              revs_d = revs_q;

        if (seq_err_d)    sticky_d = 1'b1;
        else if (Clear)   sticky_d = 1'b0;
        else              sticky_d = sticky_q;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= StHunt;
            cnt_q      <= '0;
            prev_q     <= '0;
            position_q <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            sticky_q   <= 1'b0;
            revs_q     <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            position_q <= position_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            seq_err_q  <= seq_err_d;
            sticky_q   <= sticky_d;
            revs_q     <= revs_d;
            wrap_q     <= wrap_d;
        end
    end

    assign Position    = position_q;
    assign Valid       = valid_q;
    assign Locked      = locked_q;
    assign SeqError    = seq_err_q;
    assign ErrorSticky = sticky_q;
    assign Revolutions = revs_q;
    assign Wrap        = wrap_q;

endmodule

// File: tb/tb_ring_counter_decoder.sv
// Bench for ring_counter_decoder: directed vector table, corner sequences and
// randomized traffic against a position-level reference model.
module tb_ring_counter_decoder;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned L     = 2;
    localparam int unsigned PW    = 2;

    logic             Clock = 1'b0;
    logic             Resetn;
    logic             Enable;
    logic [WIDTH-1:0] Ring;
    logic             Clear;
    logic [PW-1:0]    Position;
    logic             Valid;
    logic             Locked;
    logic             SeqError;
    logic             ErrorSticky;
    logic [7:0]       Revolutions;
    logic             Wrap;

    ring_counter_decoder #(.WIDTH(WIDTH), .LOCK_COUNT(L)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .Enable      (Enable),
        .Ring        (Ring),
        .Clear       (Clear),
        .Position    (Position),
        .Valid       (Valid),
        .Locked      (Locked),
        .SeqError    (SeqError),
        .ErrorSticky (ErrorSticky),
        .Revolutions (Revolutions),
        .Wrap        (Wrap)
    );

    always #5 Clock = ~Clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model in terms of positions: 0 hunt, 1 sync, 2 lock.
    int m_state, m_cnt, m_prev, m_pos, m_revs;
    bit m_valid, m_locked, m_seq, m_sticky, m_wrap;

    function automatic void model_reset();
        m_state = 0; m_cnt = 0; m_prev = -1; m_pos = 0; m_revs = 0;
        m_valid = 0; m_locked = 0; m_seq = 0; m_sticky = 0; m_wrap = 0;
    endfunction

    function automatic void model_step(input bit en, input logic [WIDTH-1:0] r, input bit clr);
        bit legal, succ, inc, fault;
        int p;
        inc = 0; fault = 0; p = -1;
        if (en) begin
            legal = ($countones(r) == 1);
            for (int k = 0; k < WIDTH; k++) if (r[WIDTH-1-k]) p = k;
            succ = legal && (m_prev >= 0) && (p == (m_prev + 1) % WIDTH);
            m_valid = legal;
            if (legal) m_pos = p;
            case (m_state)
                0: if (legal) begin m_state = 1; m_cnt = 0; m_prev = p; end
                1: begin
                    if (!legal) m_state = 0;
                    else if (succ) begin
                        m_cnt++; m_prev = p;
                        if (m_cnt == L) m_state = 2;
                    end else begin m_cnt = 0; m_prev = p; end
                end
                default: begin
                    if (!legal) begin fault = 1; m_state = 0; end
                    else if (succ) begin inc = (m_prev == WIDTH - 1); m_prev = p; end
                    else begin fault = 1; m_state = 1; m_cnt = 0; m_prev = p; end
                end
            endcase
        end
        if (clr) m_revs = 0;
        else if (inc) m_revs = (m_revs + 1) % 256;
        m_wrap = inc;
        m_seq  = fault;
        if (fault) m_sticky = 1;
        else if (clr) m_sticky = 0;
        m_locked = (m_state == 2);
    endfunction

    // Drive inputs just after an edge, take the next edge, sample 1 time unit later.
    task automatic step(input bit en, input logic [WIDTH-1:0] r, input bit clr);
        Enable = en; Ring = r; Clear = clr;
        @(posedge Clock);
        model_step(en, r, clr);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pos"},    int'(Position),    m_pos);
        chk({tag, ".valid"},  int'(Valid),       int'(m_valid));
        chk({tag, ".locked"}, int'(Locked),      int'(m_locked));
        chk({tag, ".seq"},    int'(SeqError),    int'(m_seq));
        chk({tag, ".sticky"}, int'(ErrorSticky), int'(m_sticky));
        chk({tag, ".revs"},   int'(Revolutions), m_revs);
        chk({tag, ".wrap"},   int'(Wrap),        int'(m_wrap));
    endtask

    task automatic mstep(input bit en, input logic [WIDTH-1:0] r, input bit clr,
                         input string tag);
        step(en, r, clr);
        check_model(tag);
    endtask

    function automatic logic [WIDTH-1:0] onehot(input int p);
        logic [WIDTH-1:0] v;
        v = '0;
        v[WIDTH-1-p] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        Resetn = 1'b0; Enable = 1'b0; Ring = '0; Clear = 1'b0;
        model_reset();
        #12;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    typedef struct {
        bit               en;
        logic [WIDTH-1:0] ring;
        bit               clr;
        int               pos;
        bit               valid, locked, seq, sticky;
        int               revs;
        bit               wrap;
    } vec_t;

    vec_t vecs[20];
    int   wraps_seen;

    initial begin
        //           en ring     clr pos v  lk se st rv w
        vecs[0]  = '{1, 4'b1000, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 4'b0100, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 4'b0010, 0, 2, 1, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 4'b0001, 0, 3, 1, 1, 0, 0, 0, 0};
        vecs[4]  = '{1, 4'b1000, 0, 0, 1, 1, 0, 0, 1, 1};
        vecs[5]  = '{1, 4'b0100, 0, 1, 1, 1, 0, 0, 1, 0};
        vecs[6]  = '{1, 4'b0001, 0, 3, 1, 0, 1, 1, 1, 0};
        vecs[7]  = '{1, 4'b1000, 0, 0, 1, 0, 0, 1, 1, 0};
        vecs[8]  = '{1, 4'b0100, 0, 1, 1, 1, 0, 1, 1, 0};
        vecs[9]  = '{1, 4'b0110, 0, 1, 0, 0, 1, 1, 1, 0};
        vecs[10] = '{1, 4'b0000, 0, 1, 0, 0, 0, 1, 1, 0};
        vecs[11] = '{1, 4'b1000, 0, 0, 1, 0, 0, 1, 1, 0};
        vecs[12] = '{1, 4'b0100, 0, 1, 1, 0, 0, 1, 1, 0};
        vecs[13] = '{1, 4'b0010, 0, 2, 1, 1, 0, 1, 1, 0};
        vecs[14] = '{0, 4'b0001, 0, 2, 1, 1, 0, 1, 1, 0};
        vecs[15] = '{1, 4'b0001, 0, 3, 1, 1, 0, 1, 1, 0};
        vecs[16] = '{0, 4'b1000, 0, 3, 1, 1, 0, 1, 1, 0};
        vecs[17] = '{1, 4'b1000, 0, 0, 1, 1, 0, 1, 2, 1};
        vecs[18] = '{1, 4'b1000, 0, 0, 1, 0, 1, 1, 2, 0};
        vecs[19] = '{1, 4'b0100, 1, 1, 1, 0, 0, 0, 0, 0};

        Resetn = 1'b0; Enable = 1'b0; Ring = '0; Clear = 1'b0;
        model_reset();
        #3;
        check_model("reset");
        #9;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        check_model("post_release");

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ring, vecs[i].clr);
            chk($sformatf("vec%0d.pos", i),    int'(Position),    vecs[i].pos);
            chk($sformatf("vec%0d.valid", i),  int'(Valid),       int'(vecs[i].valid));
            chk($sformatf("vec%0d.locked", i), int'(Locked),      int'(vecs[i].locked));
            chk($sformatf("vec%0d.seq", i),    int'(SeqError),    int'(vecs[i].seq));
            chk($sformatf("vec%0d.sticky", i), int'(ErrorSticky), int'(vecs[i].sticky));
            chk($sformatf("vec%0d.revs", i),   int'(Revolutions), vecs[i].revs);
            chk($sformatf("vec%0d.wrap", i),   int'(Wrap),        int'(vecs[i].wrap));
        end

        // 256 revolutions while locked: counter wraps back to zero.
        do_reset();
        mstep(1, 4'b1000, 0, "rev_acq");
        mstep(1, 4'b0100, 0, "rev_acq");
        mstep(1, 4'b0010, 0, "rev_acq");
        wraps_seen = 0;
        for (int r = 0; r < 256; r++) begin
            for (int p = 3; p < 7; p++) begin
                mstep(1, onehot(p % WIDTH), 0, "rev_loop");
                if (Wrap) wraps_seen++;
            end
        end
        chk("wrap_count", wraps_seen, 256);
        chk("revs_wrapped", int'(Revolutions), 0);

        // Clear on a wrap edge, then Clear together with a fault.
        mstep(1, 4'b0001, 0, "pre_clr");
        mstep(1, 4'b1000, 0, "pre_clr");
        chk("revs_one", int'(Revolutions), 1);
        mstep(1, 4'b0100, 0, "pre_clr");
        mstep(1, 4'b0010, 0, "pre_clr");
        mstep(1, 4'b0001, 0, "pre_clr");
        step(1, 4'b1000, 1);
        chk("clr_wrap.revs", int'(Revolutions), 0);
        chk("clr_wrap.wrap", int'(Wrap), 1);
        step(1, 4'b1000, 1);
        chk("clr_fault.sticky", int'(ErrorSticky), 1);
        chk("clr_fault.seq", int'(SeqError), 1);
        check_model("clr_fault");

        // Relock, then drop reset between edges.
        mstep(1, 4'b0100, 0, "relock");
        mstep(1, 4'b0010, 0, "relock");
        chk("relock.locked", int'(Locked), 1);
        #2;
        Resetn = 1'b0;
        model_reset();
        #1;
        check_model("async_reset");
        #3;
        Resetn = 1'b1;
        step(1, 4'b1000, 0);
        chk("lat0.locked", int'(Locked), 0);
        step(1, 4'b0100, 0);
        chk("lat1.locked", int'(Locked), 0);
        step(1, 4'b0010, 0);
        chk("lat2.locked", int'(Locked), 1);
        check_model("lat2");

        // Randomized traffic, biased toward legal successors so lock is reached often.
        for (int n = 0; n < 800; n++) begin
            bit               en, clr;
            logic [WIDTH-1:0] r;
            int               sel;
            en  = ($urandom_range(0, 3) != 0);
            clr = en && ($urandom_range(0, 24) == 0);
            sel = $urandom_range(0, 99);
            if (m_prev < 0 || sel < 10) r = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            else if (sel < 15) r = onehot(m_prev);
            else if (sel < 20) r = onehot($urandom_range(0, WIDTH - 1));
            else r = onehot((m_prev + 1) % WIDTH);
            mstep(en, r, clr, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
